// File: rtl/mem_wb_stage.sv
// MEM stage with data memory, branch resolution and the MEM/WB register.
// Results appear on W_* one edge after they are presented on M_*.
module mem_wb_stage #(
   parameter int MEM_WORDS = 256,
   parameter int ADDR_W    = 8
) (
   input  logic        Clk,
   input  logic        Rst_n,
   input  logic [3:0]  M_WB,
   input  logic        M_MemRead,
   input  logic        M_MemWrite,
   input  logic        M_Branch,
   input  logic        M_BNE,
   input  logic        M_BranchCon,
   input  logic        M_ZeroFlag,
   input  logic [31:0] M_PCinc,
   input  logic [31:0] M_BranchAddResult,
   input  logic [31:0] M_ALUResult,
   input  logic [31:0] M_WriteMemData,
   input  logic [31:0] M_WriteRegData,
   input  logic        Stall,
   output logic        PCSrc,
   output logic [31:0] PCTarget,
   output logic        Flush,
   output logic [3:0]  W_WB,
   output logic [31:0] W_ReadData,
   output logic [31:0] W_ALUResult,
   output logic [4:0]  W_WriteReg,
   output logic [31:0] W_PCinc,
   output logic        AddrErr
);

   logic [31:0]       mem [MEM_WORDS];
   logic [ADDR_W-1:0] idx;
   logic              valid;
   logic              taken;
   logic              do_wr;
   logic              do_rd;
   logic              bad_acc;
   logic [31:0]       rd_data;
   logic              unused_bits;

   assign unused_bits = ^M_WriteRegData[31:5];

   assign taken = M_BranchCon
                | (M_Branch & M_ZeroFlag)
                | (M_BNE & ~M_ZeroFlag);

   assign PCSrc    = taken;
   assign Flush    = taken;
   assign PCTarget = M_BranchAddResult;

   assign idx   = M_ALUResult[ADDR_W+1:2];
   assign valid = (M_ALUResult[1:0] == 2'b00)
               && (M_ALUResult[31:ADDR_W+2] == '0);

   // A simultaneous read and write is treated as a plain store.
   assign do_wr   = M_MemWrite & valid & ~Stall;
   assign do_rd   = M_MemRead & ~M_MemWrite & valid;
   assign bad_acc = (M_MemRead | M_MemWrite) & ~valid;
   assign rd_data = do_rd ? mem[idx] : 32'h0;

   // Contents survive reset; writes are only suppressed while it is held.
   always_ff @(posedge Clk) begin
      if (Rst_n && do_wr)
         mem[idx] <= M_WriteMemData;
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         W_WB        <= '0;
         W_ReadData  <= '0;
         W_ALUResult <= '0;
         W_WriteReg  <= '0;
         W_PCinc     <= '0;
      end else if (!Stall) begin
         W_WB        <= M_WB;
         W_ReadData  <= rd_data;
         W_ALUResult <= M_ALUResult;
         W_WriteReg  <= M_WriteRegData[4:0];
         W_PCinc     <= M_PCinc;
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)
         AddrErr <= 1'b0;
      else if (bad_acc)
         AddrErr <= 1'b1;
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, memory access, branches,
// address errors, stall and reset during a store.
module tb_mem_wb_stage;

   logic        Clk;
   logic        Rst_n;
   logic [3:0]  M_WB;
   logic        M_MemRead;
   logic        M_MemWrite;
   logic        M_Branch;
   logic        M_BNE;
   logic        M_BranchCon;
   logic        M_ZeroFlag;
   logic [31:0] M_PCinc;
   logic [31:0] M_BranchAddResult;
   logic [31:0] M_ALUResult;
   logic [31:0] M_WriteMemData;
   logic [31:0] M_WriteRegData;
   logic        Stall;
   logic        PCSrc;
   logic [31:0] PCTarget;
   logic        Flush;
   logic [3:0]  W_WB;
   logic [31:0] W_ReadData;
   logic [31:0] W_ALUResult;
   logic [4:0]  W_WriteReg;
   logic [31:0] W_PCinc;
   logic        AddrErr;

   int n_chk;
   int n_fail;

   mem_wb_stage #(.MEM_WORDS(256), .ADDR_W(8)) dut (
      .Clk(Clk),
      .Rst_n(Rst_n),
      .M_WB(M_WB),
      .M_MemRead(M_MemRead),
      .M_MemWrite(M_MemWrite),
      .M_Branch(M_Branch),
      .M_BNE(M_BNE),
      .M_BranchCon(M_BranchCon),
      .M_ZeroFlag(M_ZeroFlag),
      .M_PCinc(M_PCinc),
      .M_BranchAddResult(M_BranchAddResult),
      .M_ALUResult(M_ALUResult),
      .M_WriteMemData(M_WriteMemData),
      .M_WriteRegData(M_WriteRegData),
      .Stall(Stall),
      .PCSrc(PCSrc),
      .PCTarget(PCTarget),
      .Flush(Flush),
      .W_WB(W_WB),
      .W_ReadData(W_ReadData),
      .W_ALUResult(W_ALUResult),
      .W_WriteReg(W_WriteReg),
      .W_PCinc(W_PCinc),
      .AddrErr(AddrErr)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      M_WB              = 4'b0000;
      M_MemRead         = 1'b0;
      M_MemWrite        = 1'b0;
      M_Branch          = 1'b0;
      M_BNE             = 1'b0;
      M_BranchCon       = 1'b0;
      M_ZeroFlag        = 1'b0;
      M_PCinc           = 32'h0;
      M_BranchAddResult = 32'h0;
      M_ALUResult       = 32'h0;
      M_WriteMemData    = 32'h0;
      M_WriteRegData    = 32'h0;
      Stall             = 1'b0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      idle();
      M_MemWrite     = 1'b1;
      M_ALUResult    = a;
      M_WriteMemData = d;
   endtask

   task automatic load(input logic [31:0] a, input logic [3:0] wb);
      idle();
      M_MemRead   = 1'b1;
      M_ALUResult = a;
      M_WB        = wb;
   endtask

   task automatic br(input logic b, input logic bne,
                     input logic j, input logic z,
                     input logic exp, input string tag);
      idle();
      M_Branch          = b;
      M_BNE             = bne;
      M_BranchCon       = j;
      M_ZeroFlag        = z;
      M_BranchAddResult = 32'h40;
      #1;
      check({tag, "_pcsrc"}, {31'h0, PCSrc}, {31'h0, exp});
      check({tag, "_flush"}, {31'h0, Flush}, {31'h0, exp});
   endtask

   task automatic rst_pulse();
      #3;
      Rst_n = 1'b0;
      #1;
      Rst_n = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      idle();
      Rst_n = 1'b0;
      #12;
      check("rst_wb", {28'h0, W_WB}, 32'h0);
      check("rst_err", {31'h0, AddrErr}, 32'h0);
      Rst_n = 1'b1;

      // Seed memory contents used later
      store(32'h14, 32'h0);          step();
      store(32'h0, 32'h5555_0000);   step();
      store(32'hC, 32'h0C0C_0C0C);   step();
      store(32'h20, 32'h2020_2020);  step();

      // Async reset mid-cycle
      idle();
      M_WB        = 4'b1100;
      M_ALUResult = 32'h77;
      M_PCinc     = 32'h104;
      step();
      check("pre_rst_wb", {28'h0, W_WB}, 32'hC);
      check("pre_rst_alu", W_ALUResult, 32'h77);
      #2;
      Rst_n = 1'b0;
      #1;
      check("arst_wb", {28'h0, W_WB}, 32'h0);
      check("arst_alu", W_ALUResult, 32'h0);
      check("arst_pc", W_PCinc, 32'h0);
      check("arst_rd", W_ReadData, 32'h0);
      check("arst_wr", {27'h0, W_WriteReg}, 32'h0);
      check("arst_err", {31'h0, AddrErr}, 32'h0);
      Rst_n = 1'b1;

      // Store then load same address
      store(32'h10, 32'hDEAD_BEEF);
      step();
      load(32'h10, 4'b1101);
      M_WriteRegData = 32'hFFFF_FFE5;
      M_PCinc        = 32'h208;
      step();
      check("ld10_data", W_ReadData, 32'hDEAD_BEEF);
      check("ld10_wb", {28'h0, W_WB}, 32'hD);
      check("ld10_reg", {27'h0, W_WriteReg}, 32'h5);
      check("ld10_pc", W_PCinc, 32'h208);
      load(32'h14, 4'b1100);
      step();
      check("ld14_data", W_ReadData, 32'h0);

      // Read and write together behaves as a store
      store(32'h24, 32'h2424_2424);
      M_MemRead = 1'b1;
      step();
      check("rw_data", W_ReadData, 32'h0);
      load(32'h24, 4'b1100);
      step();
      check("rw_stored", W_ReadData, 32'h2424_2424);

      // Branch resolution
      br(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "beq_z1");
      check("beq_tgt", PCTarget, 32'h40);
      br(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "beq_z0");
      br(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "bne_z1");
      br(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, "bne_z0");
      br(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, "jmp_z0");
      br(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, "jmp_z1");
      br(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "none");
      Stall = 1'b1;
      M_BranchCon = 1'b1;
      #1;
      check("jmp_stall", {31'h0, PCSrc}, 32'h1);

      // Misaligned load
      load(32'h13, 4'b1100);
      step();
      check("mis_err", {31'h0, AddrErr}, 32'h1);
      check("mis_data", W_ReadData, 32'h0);
      idle();
      step();
      check("err_sticky", {31'h0, AddrErr}, 32'h1);
      rst_pulse();
      check("err_clr", {31'h0, AddrErr}, 32'h0);

      // Out-of-range store aliases word 0 if not dropped
      store(32'h400, 32'h0BAD_0BAD);
      step();
      check("oor_err", {31'h0, AddrErr}, 32'h1);
      load(32'h0, 4'b1110);
      step();
      check("oor_keep", W_ReadData, 32'h5555_0000);
      check("oor_wb", {28'h0, W_WB}, 32'hE);

      // Stalled store to 0xC must not land
      store(32'hC, 32'h9999_9999);
      M_WB  = 4'b0011;
      Stall = 1'b1;
      step();
      check("stl_wb", {28'h0, W_WB}, 32'hE);
      check("stl_alu", W_ALUResult, 32'h0);
      check("stl_rd", W_ReadData, 32'h5555_0000);
      load(32'hC, 4'b1000);
      step();
      check("stl_mem", W_ReadData, 32'h0C0C_0C0C);

      // Stalled store lands once stall drops
      store(32'h8, 32'h0000_1234);
      M_WB  = 4'b0011;
      Stall = 1'b1;
      step();
      step();
      check("stl2_wb", {28'h0, W_WB}, 32'h8);
      check("stl2_alu", W_ALUResult, 32'hC);
      Stall = 1'b0;
      step();
      check("unstl_wb", {28'h0, W_WB}, 32'h3);
      check("unstl_alu", W_ALUResult, 32'h8);
      load(32'h8, 4'b1100);
      step();
      check("unstl_mem", W_ReadData, 32'h0000_1234);

      // Reset held across the edge of a store
      store(32'h20, 32'h0000_AAAA);
      #6;
      Rst_n = 1'b0;
      @(posedge Clk);
      #2;
      Rst_n = 1'b1;
      load(32'h20, 4'b1100);
      step();
      check("rst_st20", W_ReadData, 32'h2020_2020);
      load(32'h10, 4'b1100);
      step();
      check("rst_st10", W_ReadData, 32'hDEAD_BEEF);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
